pmp_csr_regs: RTL and testbench

- Holds the PMP CSR state (pmpcfg bytes and pmpaddr registers) for the core and drives the packed configuration bus consumed by the PMP checker.
- Sits between the CSR file's write/read datapath and the combinational PMP checker.
- Enforces lock semantics and WARL legalisation on writes.
- Provides a registered read port and a one-cycle change pulse so downstream TLB/PMP caches can flush.

---
 rtl/pmp_csr_regs.sv | 124 ++++++++++++
 tb/tb_pmp_csr_regs.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/pmp_csr_regs.sv
`default_nettype none
// ============================================================================
// Module      : pmp_csr_regs
// Description : PMP CSR storage (pmpcfg bytes and pmpaddr registers) with
//               lock/WARL write legalisation, a registered read port and a
//               one-cycle change pulse for downstream PMP/TLB cache flushes.
// Revision    : 1.0 - initial release
// ============================================================================
module pmp_csr_regs #(
    parameter int NR_ENTRIES = 4,
    parameter int PMP_LEN    = 32
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic                          csr_we_i,
    input  logic                          csr_re_i,
    input  logic [11:0]                   csr_addr_i,
    input  logic [31:0]                   csr_wdata_i,
    output logic [31:0]                   csr_rdata_o,
    output logic                          csr_rvalid_o,
    output logic                          csr_err_o,
    output logic [NR_ENTRIES*PMP_LEN-1:0] conf_addr_o,
    output logic [NR_ENTRIES*8-1:0]       conf_o,
    output logic                          cfg_changed_o
);

    // Architectural maximum; entries at or above NR_ENTRIES read as zero.
    localparam int c_MAX_ENTRIES = 16;

    logic [7:0]              w_cfg  [c_MAX_ENTRIES];
    logic [PMP_LEN-1:0]      w_addr [c_MAX_ENTRIES];
    logic [c_MAX_ENTRIES-1:0] w_chg;

    logic        w_is_cfg;
    logic        w_is_addr;
    logic        w_in_space;
    logic [31:0] w_rdata;

    // pmpcfg0..3 live at 0x3A0..0x3A3, pmpaddr0..15 at 0x3B0..0x3BF.
    assign w_is_cfg   = (csr_addr_i[11:4] == 8'h3A) && (csr_addr_i[3:2] == 2'b00);
    assign w_is_addr  = (csr_addr_i[11:4] == 8'h3B);
    assign w_in_space = w_is_cfg || w_is_addr;

    for (genvar gi = 0; gi < c_MAX_ENTRIES; gi++) begin : g_entry
        if (gi < NR_ENTRIES) begin : g_impl
            logic [7:0]         r_cfg;
            logic [PMP_LEN-1:0] r_addr;
            logic [7:0]         w_new_byte;
            logic [7:0]         w_legal;
            logic               w_cfg_we;
            logic               w_addr_we;
            logic               w_tor_lock;

            assign w_cfg_we   = csr_we_i && w_is_cfg && (csr_addr_i[1:0] == 2'(gi / 4));
            assign w_new_byte = csr_wdata_i[(gi % 4) * 8 +: 8];
            // Locked entries and the reserved R=0/W=1 combination keep the old byte.
            assign w_legal    = (r_cfg[7] || (!w_new_byte[0] && w_new_byte[1])) ?
                                r_cfg : {w_new_byte[7], 2'b00, w_new_byte[4:0]};

            // A locked TOR entry above also freezes this entry's address (its base).
            if (gi + 1 < NR_ENTRIES) begin : g_tor
                assign w_tor_lock = w_cfg[gi + 1][7] && (w_cfg[gi + 1][4:3] == 2'b01);
            end else begin : g_no_tor
                assign w_tor_lock = 1'b0;
            end

            assign w_addr_we = csr_we_i && w_is_addr && (csr_addr_i[3:0] == 4'(gi)) &&
                               !r_cfg[7] && !w_tor_lock;

            // Entry state: commits legalised cfg byte and unlocked address writes.
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_cfg  <= '0;
                    r_addr <= '0;
                end else begin
                    if (w_cfg_we)  r_cfg  <= w_legal;
                    if (w_addr_we) r_addr <= csr_wdata_i[PMP_LEN-1:0];
                end
            end

            assign w_chg[gi]  = (w_cfg_we && (w_legal != r_cfg)) ||
                                (w_addr_we && (csr_wdata_i[PMP_LEN-1:0] != r_addr));
            assign w_cfg[gi]  = r_cfg;
            assign w_addr[gi] = r_addr;
        end else begin : g_unimpl
            assign w_cfg[gi]  = '0;
            assign w_addr[gi] = '0;
            assign w_chg[gi]  = 1'b0;
        end
    end

    for (genvar gp = 0; gp < NR_ENTRIES; gp++) begin : g_pack
        assign conf_o[gp * 8 +: 8]                = w_cfg[gp];
        assign conf_addr_o[gp * PMP_LEN +: PMP_LEN] = w_addr[gp];
    end

    // Read mux over pre-write state; non-PMP addresses return zero.
    always_comb begin
        w_rdata = '0;
        if (w_is_cfg) begin
            w_rdata = {w_cfg[{csr_addr_i[1:0], 2'd3}], w_cfg[{csr_addr_i[1:0], 2'd2}],
                       w_cfg[{csr_addr_i[1:0], 2'd1}], w_cfg[{csr_addr_i[1:0], 2'd0}]};
        end else if (w_is_addr) begin
            w_rdata[PMP_LEN-1:0] = w_addr[csr_addr_i[3:0]];
        end
    end

    // Registered response: read data/valid, address error and change pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            csr_rdata_o   <= '0;
            csr_rvalid_o  <= 1'b0;
            csr_err_o     <= 1'b0;
            cfg_changed_o <= 1'b0;
        end else begin
            csr_rvalid_o  <= csr_re_i;
            csr_err_o     <= (csr_we_i || csr_re_i) && !w_in_space;
            cfg_changed_o <= |w_chg;
            if (csr_re_i) csr_rdata_o <= w_rdata;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pmp_csr_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_pmp_csr_regs
// Description : Directed self-checking bench for pmp_csr_regs (4 entries).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pmp_csr_regs;

    logic         clk_i = 1'b0;
    logic         rst_ni;
    logic         csr_we_i;
    logic         csr_re_i;
    logic [11:0]  csr_addr_i;
    logic [31:0]  csr_wdata_i;
    logic [31:0]  csr_rdata_o;
    logic         csr_rvalid_o;
    logic         csr_err_o;
    logic [127:0] conf_addr_o;
    logic [31:0]  conf_o;
    logic         cfg_changed_o;

    int n_checks = 0;
    int n_fail   = 0;

    pmp_csr_regs #(.NR_ENTRIES(4), .PMP_LEN(32)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .csr_we_i     (csr_we_i),
        .csr_re_i     (csr_re_i),
        .csr_addr_i   (csr_addr_i),
        .csr_wdata_i  (csr_wdata_i),
        .csr_rdata_o  (csr_rdata_o),
        .csr_rvalid_o (csr_rvalid_o),
        .csr_err_o    (csr_err_o),
        .conf_addr_o  (conf_addr_o),
        .conf_o       (conf_o),
        .cfg_changed_o(cfg_changed_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one access at a falling edge; returns at the next falling edge
    // so the registered response is visible.
    task automatic access(input logic we, input logic re, input logic [11:0] a, input logic [31:0] d);
        csr_we_i    = we;
        csr_re_i    = re;
        csr_addr_i  = a;
        csr_wdata_i = d;
        @(posedge clk_i);
        @(negedge clk_i);
        csr_we_i    = 1'b0;
        csr_re_i    = 1'b0;
        csr_addr_i  = '0;
        csr_wdata_i = '0;
    endtask

    task automatic wr(input logic [11:0] a, input logic [31:0] d);
        access(1'b1, 1'b0, a, d);
    endtask

    task automatic rd(input logic [11:0] a);
        access(1'b0, 1'b1, a, 32'h0);
    endtask

    task automatic idle();
        access(1'b0, 1'b0, 12'h0, 32'h0);
    endtask

    initial begin
        rst_ni      = 1'b0;
        csr_we_i    = 1'b0;
        csr_re_i    = 1'b0;
        csr_addr_i  = '0;
        csr_wdata_i = '0;
        repeat (3) @(negedge clk_i);
        check("rst_conf", conf_o, 0);
        check("rst_conf_addr", conf_addr_o, 0);
        check("rst_rvalid", csr_rvalid_o, 0);
        check("rst_err", csr_err_o, 0);
        check("rst_changed", cfg_changed_o, 0);
        check("rst_rdata", csr_rdata_o, 0);
        rst_ni = 1'b1;
        @(negedge clk_i);

        // Read after reset
        rd(12'h3A0);
        check("rd0_rvalid", csr_rvalid_o, 1);
        check("rd0_rdata", csr_rdata_o, 32'h0);
        check("rd0_err", csr_err_o, 0);
        idle();
        check("idle_rvalid", csr_rvalid_o, 0);

        // Basic cfg write
        wr(12'h3A0, 32'h0000_0F1B);
        check("cfg_wr_changed", cfg_changed_o, 1);
        check("cfg_wr_conf", conf_o, 32'h0000_0F1B);
        idle();
        check("changed_single_pulse", cfg_changed_o, 0);
        rd(12'h3A0);
        check("cfg_rd", csr_rdata_o, 32'h0000_0F1B);

        // Lock semantics
        wr(12'h3B0, 32'h0000_1234);
        check("addr0_wr_changed", cfg_changed_o, 1);
        check("addr0_val", conf_addr_o[31:0], 32'h1234);
        wr(12'h3A0, 32'h0000_881B);
        check("lock_wr_changed", cfg_changed_o, 1);
        check("lock_conf", conf_o, 32'h0000_881B);
        wr(12'h3B0, 32'h0000_FFFF);
        check("tor_lock_addr0", conf_addr_o[31:0], 32'h1234);
        check("tor_lock_nochg", cfg_changed_o, 0);
        wr(12'h3A0, 32'h0000_001B);
        check("locked_byte1", conf_o, 32'h0000_881B);
        check("locked_nochg", cfg_changed_o, 0);

        // WARL legalisation
        wr(12'h3A0, 32'h0000_8862);
        check("rsvd_rw_keep", conf_o, 32'h0000_881B);
        check("rsvd_rw_nochg", cfg_changed_o, 0);
        wr(12'h3A0, 32'h0000_8863);
        check("bits65_zero", conf_o, 32'h0000_8803);
        check("bits65_chg", cfg_changed_o, 1);

        // Own-lock on address, unlocked address, identical write
        wr(12'h3B1, 32'h0000_AAAA);
        check("self_lock_addr1", conf_addr_o[63:32], 32'h0);
        check("self_lock_nochg", cfg_changed_o, 0);
        wr(12'h3B2, 32'h0000_5555);
        check("addr2_val", conf_addr_o[95:64], 32'h5555);
        check("addr2_chg", cfg_changed_o, 1);
        wr(12'h3B2, 32'h0000_5555);
        check("same_wr_nochg", cfg_changed_o, 0);

        // Read during write to the same CSR returns old value
        access(1'b1, 1'b1, 12'h3B2, 32'hDEAD_7777);
        check("rdw_old", csr_rdata_o, 32'h0000_5555);
        check("rdw_rvalid", csr_rvalid_o, 1);
        check("rdw_chg", cfg_changed_o, 1);
        rd(12'h3B2);
        check("rdw_new", csr_rdata_o, 32'hDEAD_7777);
        idle();
        check("rdata_hold", csr_rdata_o, 32'hDEAD_7777);
        check("hold_rvalid", csr_rvalid_o, 0);

        // Unimplemented entries and out-of-space addresses
        rd(12'h3B7);
        check("unimpl_addr_rd", csr_rdata_o, 32'h0);
        check("unimpl_addr_err", csr_err_o, 0);
        wr(12'h3A1, 32'hFFFF_FFFF);
        check("unimpl_cfg_wr_err", csr_err_o, 0);
        check("unimpl_cfg_wr_chg", cfg_changed_o, 0);
        rd(12'h3A1);
        check("unimpl_cfg_rd", csr_rdata_o, 32'h0);
        rd(12'h300);
        check("bad_rd_err", csr_err_o, 1);
        check("bad_rd_rvalid", csr_rvalid_o, 1);
        check("bad_rd_rdata", csr_rdata_o, 32'h0);
        wr(12'h3A4, 32'h0000_00FF);
        check("bad_wr_err", csr_err_o, 1);
        check("bad_wr_rvalid", csr_rvalid_o, 0);
        check("bad_wr_conf", conf_o, 32'h0000_8803);

        // Asynchronous reset in the middle of a read
        csr_re_i   = 1'b1;
        csr_addr_i = 12'h3B2;
        rst_ni     = 1'b0;
        #1;
        check("arst_conf", conf_o, 0);
        check("arst_conf_addr", conf_addr_o, 0);
        check("arst_rdata", csr_rdata_o, 0);
        @(posedge clk_i);
        @(negedge clk_i);
        check("arst_discard", csr_rvalid_o, 0);
        csr_re_i   = 1'b0;
        csr_addr_i = '0;
        rst_ni     = 1'b1;
        @(negedge clk_i);
        wr(12'h3B0, 32'h0000_0099);
        check("post_rst_unlocked", conf_addr_o[31:0], 32'h99);
        check("post_rst_chg", cfg_changed_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
